spart: RTL and testbench
========================

Name: spart

Overview:
- Special-purpose async receiver/transmitter; sits directly downstream of the bus driver FSM.
- Decodes driver bus transactions (iocs/iorw/ioaddr/databus) to program a 16-bit baud divisor, accept transmit bytes, and return received bytes and status.
- Serialises 8N1 frames on txd and deserialises frames from rxd; reports rda/tbr back to the driver.

Parameters:
DEFAULT_DIV, 16'h1458, divisor loaded at reset (clk cycles per bit; 9600 baud at 50 MHz)
MIN_DIV, 16'd4, smallest divisor honoured; smaller programmed values are treated as MIN_DIV

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
iocs  input  1  chip select; no register access when 0
iorw  input  1  1 = read (spart drives databus), 0 = write (driver drives databus)
ioaddr  input  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
databus  inout  8  shared bidirectional bus
rda  output  1  receive data available
tbr  output  1  transmit buffer ready (transmitter idle)
txd  output  1  serial out, idle high
rxd  input  1  serial in, asynchronous to clk

Behaviour:
- Reset (rst=0, async): divisor=DEFAULT_DIV, txd=1, tbr=1, rda=0, rx buffer=0, status flags=0, both FSMs IDLE, databus released (Z).
- Bus drive: databus driven only when iocs=1 and iorw=1; otherwise Z. Read data is combinational from registers.
  - ioaddr 00 gives rx buffer. ioaddr 01 gives {4'b0, overrun, framing_err, tbr, rda}. ioaddr 10/11 gives divisor low/high.
- Writes: sampled on each posedge with iocs=1 and iorw=0. Repeated writes of the same value are harmless.
  - ioaddr 10 loads divisor[7:0]. ioaddr 11 loads divisor[15:8].
  - ioaddr 00 with tbr=1 starts TX. ioaddr 00 with tbr=0 is ignored. ioaddr 01 write is ignored.
- Read side-effects:
  - A cycle with iocs=1, iorw=1, ioaddr=00 clears rda at the next edge.
  - A status read clears framing_err and overrun at the next edge.
- Effective divisor: eff_div = max(divisor, MIN_DIV). A divisor change mid-frame takes effect at the next bit-counter reload, never truncates the current bit.
- TX FSM, states IDLE, SHIFT:
  - IDLE: tbr=1, txd=1. On an accepted write, the 10-bit shift register is loaded with {1 stop, data[7:0], 0 start}, tbr goes 0, and the FSM enters SHIFT. txd goes low on the cycle after the write edge.
  - SHIFT: each bit is held for exactly eff_div clocks, LSB first after the start bit. After the stop bit completes (10*eff_div clocks total), return to IDLE and tbr=1 on the same edge.
- RX front end: rxd passes through a 2-flop synchroniser (2-cycle latency); falling-edge detect runs on the synchronised value.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: a falling edge loads the counter with eff_div/2 (floor) and enters START.
  - START: at counter expiry, if the sample is 1 it is a false start and the FSM returns to IDLE with no flags. If 0, reload eff_div and enter DATA.
  - DATA: sample at each eff_div expiry, shifting LSB first; after 8 samples enter STOP.
  - STOP: at expiry, if the sample is 1, load the rx buffer and set rda=1. If rda was already 1, also set overrun=1 and the new byte overwrites the buffer. If the sample is 0, discard the byte, set framing_err=1, leave rda unchanged.
  - Return to IDLE in either STOP case. A new falling edge is recognised starting the cycle after STOP completes.
- Simultaneous events:
  - Byte completion and an rx-buffer read on the same edge: the new byte wins, rda stays 1, no overrun.
  - Flag set and status read on the same edge: the set wins.
- TX and RX are fully independent; loopback (txd tied to rxd) must work.
- Reset mid-frame aborts both FSMs immediately. txd returns to 1 asynchronously and the divisor reverts to DEFAULT_DIV.

Test Plan:
- Reset values: assert rst=0 mid-TX → txd=1, tbr=1, rda=0, databus=Z; status read returns 8'h02 and divisor reads back 16'h1458.
- Program and transmit: write 10←8'h10, 11←8'h00, then 00←8'hA5 → tbr=0 the next cycle; txd sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 16 clocks; tbr=1 exactly 160 clocks after the write.
- Write while busy: write 8'h3C during an 8'hA5 frame → ignored, the 8'hA5 frame is unchanged, no second frame.
- Receive: divisor=16, drive an 8'h5A frame on rxd → rda=1 after the stop bit; reading ioaddr 00 returns 8'h5A and rda=0 on the next cycle.
- Errors:
  - A 6-clock low glitch on rxd is a false start → no rda, no flags.
  - A frame with stop=0 → framing_err=1 (status 8'h06 with tbr=1), cleared after the status read.
  - Two frames received without a read → overrun=1, rx buffer holds the second byte.
- Loopback with divisor 4 (program 8'h01, clamp to MIN_DIV): txd→rxd sending 8'hFF then 8'h00 → both bytes received intact, 40 clocks per frame.

Source files
------------

// File: rtl/spart_if.sv
// Register-access handshake between the bus driver FSM and the spart.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart.sv
// Special-purpose UART: programmable 16-bit divisor, 8N1 transmitter and receiver,
// register access over a shared bidirectional 8-bit bus.
module spart #(
  parameter logic [15:0] DEFAULT_DIV = 16'h1458,
  parameter logic [15:0] MIN_DIV     = 16'd4
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FRAME_W = 10;

  typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  eff_div;
  logic [DATA_W-1:0] rx_buf;
  logic [DATA_W-1:0] rd_data;
  logic              rda;
  logic              tbr;
  logic              overrun;
  logic              framing_err;
  logic              wr;
  logic              rd_buf;
  logic              rd_stat;

  assign wr      = bus.iocs & ~bus.iorw;
  assign rd_buf  = bus.iocs & bus.iorw & (bus.ioaddr == 2'b00);
  assign rd_stat = bus.iocs & bus.iorw & (bus.ioaddr == 2'b01);
  assign eff_div = (divisor < MIN_DIV) ? MIN_DIV : divisor;
  assign bus.rda = rda;
  assign bus.tbr = tbr;

  // Read mux and bus drive
  always_comb begin
    rd_data = rx_buf;
    case (bus.ioaddr)
      2'b01:   rd_data = {4'b0000, overrun, framing_err, tbr, rda};
      2'b10:   rd_data = divisor[7:0];
      2'b11:   rd_data = divisor[15:8];
      default: rd_data = rx_buf;
    endcase
  end

  assign databus = (bus.iocs & bus.iorw & rst) ? rd_data : 8'hzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor <= DEFAULT_DIV;
    end else if (wr && bus.ioaddr == 2'b10) begin
      divisor[7:0] <= databus;
    end else if (wr && bus.ioaddr == 2'b11) begin
      divisor[15:8] <= databus;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t          tx_state, tx_next;
  logic [FRAME_W-1:0] tx_shreg;
  logic [DIV_W-1:0]   tx_cnt;
  logic [3:0]         tx_bits;
  logic               tx_load, tx_shift, tx_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    tx_done  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (wr && bus.ioaddr == 2'b00) begin
          tx_load = 1'b1;
          tx_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (tx_cnt == '0) begin
          if (tx_bits == 4'(FRAME_W - 1)) begin
            tx_done = 1'b1;
            tx_next = TX_IDLE;
          end else begin
            tx_shift = 1'b1;
          end
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // Bit counter reloads from eff_div only at a bit boundary, so divisor edits never cut a bit short
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shreg <= '1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      txd      <= 1'b1;
      tbr      <= 1'b1;
    end else if (tx_load) begin
      tx_shreg <= {1'b1, databus, 1'b0};
      tx_cnt   <= eff_div - DIV_W'(1);
      tx_bits  <= '0;
      txd      <= 1'b0;
      tbr      <= 1'b0;
    end else if (tx_shift) begin
      tx_shreg <= {1'b1, tx_shreg[FRAME_W-1:1]};
      tx_cnt   <= eff_div - DIV_W'(1);
      tx_bits  <= tx_bits + 4'd1;
      txd      <= tx_shreg[1];
    end else if (tx_done) begin
      txd <= 1'b1;
      tbr <= 1'b1;
    end else if (tx_state == TX_SHIFT) begin
      tx_cnt <= tx_cnt - DIV_W'(1);
    end
  end

  // ---------------- receiver ----------------
  logic              rx_s1, rx_s2, rx_prev, rx_fall;
  rx_state_t         rx_state, rx_next;
  logic [DIV_W-1:0]  rx_cnt;
  logic [2:0]        rx_bits;
  logic [DATA_W-1:0] rx_shreg;
  logic              rx_arm, rx_reload, rx_sample, byte_done, frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next   = rx_state;
    rx_arm    = 1'b0;
    rx_reload = 1'b0;
    rx_sample = 1'b0;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_arm  = 1'b1;
          rx_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_s2) begin
            rx_next = RX_IDLE;
          end else begin
            rx_reload = 1'b1;
            rx_next   = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sample = 1'b1;
          rx_reload = 1'b1;
          if (rx_bits == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_next   = RX_IDLE;
          byte_done = rx_s2;
          frame_err = ~rx_s2;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Half-divisor arm centres the start-bit sample; later samples land mid-bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shreg <= '0;
    end else begin
      if (rx_arm)                    rx_cnt <= (eff_div >> 1) - DIV_W'(1);
      else if (rx_reload)            rx_cnt <= eff_div - DIV_W'(1);
      else if (rx_state != RX_IDLE)  rx_cnt <= rx_cnt - DIV_W'(1);

      if (rx_arm)         rx_bits <= '0;
      else if (rx_sample) rx_bits <= rx_bits + 3'd1;

      if (rx_sample) rx_shreg <= {rx_s2, rx_shreg[DATA_W-1:1]};
    end
  end

  // Status flags: a new event beats a same-cycle clearing read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf      <= '0;
      rda         <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (byte_done) rx_buf <= rx_shreg;

      if (byte_done)   rda <= 1'b1;
      else if (rd_buf) rda <= 1'b0;

      if (byte_done && rda && !rd_buf) overrun <= 1'b1;
      else if (rd_stat)                overrun <= 1'b0;

      if (frame_err)    framing_err <= 1'b1;
      else if (rd_stat) framing_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spart.sv
// Directed bench for spart: reset, transmit timing, busy writes, receive, error flags, loopback.
module tb_spart;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drv_data;
  logic       drv_en;
  logic       txd;
  logic       rxd_drv;
  logic       loop_en;
  wire  [7:0] databus;
  wire        rxd;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n        = 0;
  logic [7:0] rd;
  logic [9:0] a5_bits;

  always #5 clk = ~clk;

  spart_if bus ();

  assign databus = drv_en ? drv_data : 8'hzz;
  assign rxd     = loop_en ? txd : rxd_drv;

  spart dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .databus (databus),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
    n = n + k;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] data);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b0;
    bus.ioaddr = addr;
    drv_data   = data;
    drv_en     = 1'b1;
    step(1);
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b1;
    drv_en     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] data);
    bus.iocs   = 1'b1;
    bus.iorw   = 1'b1;
    bus.ioaddr = addr;
    drv_en     = 1'b0;
    #1;
    data = databus;
    step(1);
    bus.iocs   = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    rxd_drv = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      step(16);
    end
    rxd_drv = stop;
    step(16);
    rxd_drv = 1'b1;
  endtask

  initial begin
    a5_bits    = 10'b1101001010;
    rst        = 1'b0;
    bus.iocs   = 1'b0;
    bus.iorw   = 1'b1;
    bus.ioaddr = 2'b00;
    drv_en     = 1'b0;
    drv_data   = 8'h00;
    rxd_drv    = 1'b1;
    loop_en    = 1'b0;

    // Reset state
    step(2);
    chk("reset_txd", 16'(txd), 16'h1);
    chk("reset_tbr", 16'(bus.tbr), 16'h1);
    chk("reset_rda", 16'(bus.rda), 16'h0);
    drv_en   = 1'b1;
    drv_data = 8'h96;
    #1;
    chk("bus_released", 16'(databus), 16'h96);
    drv_en   = 1'b0;
    step(1);
    rst = 1'b1;
    step(2);

    // Async reset in the middle of a default-divisor frame
    bus_write(2'b00, 8'hA5);
    step(100);
    chk("midtx_txd", 16'(txd), 16'h0);
    chk("midtx_tbr", 16'(bus.tbr), 16'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_txd", 16'(txd), 16'h1);
    chk("async_rst_tbr", 16'(bus.tbr), 16'h1);
    chk("async_rst_rda", 16'(bus.rda), 16'h0);
    step(1);
    rst = 1'b1;
    step(2);
    bus_read(2'b01, rd); chk("reset_status", 16'(rd), 16'h02);
    bus_read(2'b10, rd); chk("reset_div_lo", 16'(rd), 16'h58);
    bus_read(2'b11, rd); chk("reset_div_hi", 16'(rd), 16'h14);

    // Divisor 16, transmit 8'hA5
    bus_write(2'b10, 8'h10);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, rd); chk("div_lo_16", 16'(rd), 16'h10);
    bus_write(2'b00, 8'hA5);
    n = 0;
    chk("tx_tbr_low", 16'(bus.tbr), 16'h0);
    chk("tx_start_low", 16'(txd), 16'h0);
    step(8);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d", i), 16'(txd), 16'(a5_bits[i]));
      if (i < 9) step(16);
    end
    step(7);
    chk("tx_tbr_159", 16'(bus.tbr), 16'h0);
    step(1);
    chk("tx_tbr_160", 16'(bus.tbr), 16'h1);
    chk("tx_idle_txd", 16'(txd), 16'h1);

    // Write while busy is ignored
    bus_write(2'b00, 8'hA5);
    n = 0;
    step(8);
    chk("busy_bit0", 16'(txd), 16'(a5_bits[0]));
    step(16);
    chk("busy_bit1", 16'(txd), 16'(a5_bits[1]));
    step(6);
    bus_write(2'b00, 8'h3C);
    step(9);
    for (int i = 2; i < 10; i++) begin
      chk($sformatf("busy_bit%0d", i), 16'(txd), 16'(a5_bits[i]));
      if (i < 9) step(16);
    end
    step(8);
    chk("busy_tbr_160", 16'(bus.tbr), 16'h1);
    step(20);
    chk("busy_no_2nd_tbr", 16'(bus.tbr), 16'h1);
    chk("busy_no_2nd_txd", 16'(txd), 16'h1);

    // Receive 8'h5A
    chk("rx_rda_before", 16'(bus.rda), 16'h0);
    rx_frame(8'h5A, 1'b1);
    step(2);
    chk("rx_rda_set", 16'(bus.rda), 16'h1);
    bus_read(2'b00, rd); chk("rx_data_5a", 16'(rd), 16'h5A);
    chk("rx_rda_cleared", 16'(bus.rda), 16'h0);
    bus_read(2'b01, rd); chk("rx_status", 16'(rd), 16'h02);

    // 6-clock glitch is a false start
    rxd_drv = 1'b0;
    step(6);
    rxd_drv = 1'b1;
    step(40);
    chk("glitch_rda", 16'(bus.rda), 16'h0);
    bus_read(2'b01, rd); chk("glitch_status", 16'(rd), 16'h02);

    // Framing error
    rx_frame(8'h33, 1'b0);
    step(2);
    bus_read(2'b01, rd); chk("frame_status", 16'(rd), 16'h06);
    bus_read(2'b01, rd); chk("frame_cleared", 16'(rd), 16'h02);
    chk("frame_rda", 16'(bus.rda), 16'h0);

    // Overrun
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    step(2);
    bus_read(2'b01, rd); chk("ovr_status", 16'(rd), 16'h0B);
    bus_read(2'b00, rd); chk("ovr_data", 16'(rd), 16'h22);
    bus_read(2'b01, rd); chk("ovr_cleared", 16'(rd), 16'h02);

    // Loopback at clamped divisor 4
    loop_en = 1'b1;
    bus_write(2'b10, 8'h01);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, rd); chk("lb_div_raw", 16'(rd), 16'h01);
    bus_write(2'b00, 8'hFF);
    step(39);
    chk("lb_ff_tbr39", 16'(bus.tbr), 16'h0);
    step(1);
    chk("lb_ff_tbr40", 16'(bus.tbr), 16'h1);
    step(4);
    chk("lb_ff_rda", 16'(bus.rda), 16'h1);
    bus_read(2'b00, rd); chk("lb_ff_data", 16'(rd), 16'hFF);
    bus_write(2'b00, 8'h00);
    step(39);
    chk("lb_00_tbr39", 16'(bus.tbr), 16'h0);
    step(1);
    chk("lb_00_tbr40", 16'(bus.tbr), 16'h1);
    step(4);
    chk("lb_00_rda", 16'(bus.rda), 16'h1);
    bus_read(2'b00, rd); chk("lb_00_data", 16'(rd), 16'h00);
    bus_read(2'b01, rd); chk("lb_status", 16'(rd), 16'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
